uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- UART receiver plus small receive FIFO, sitting directly upstream of the machine's UART peripheral.
- Takes the raw asynchronous rx pad (IOB_16A) and delivers framed bytes to the bus-side register logic via a first-word-fall-through pop interface.
- Frame format is 8N1, LSB first, with 16x oversampling.
- Reports framing errors and overruns as single-cycle pulses for the CPU-visible status register.

Parameters:
- CLK_HZ, 24000000, system clock frequency (PLL output).
- BAUD, 115200, line rate.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  raw asynchronous serial input; idles high.
- rd_en  input  1  pop request; honoured only when rd_valid=1.
- rd_data  output  8  byte at FIFO head; valid while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- busy  output  1  receiver currently inside a frame (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because FIFO was full.

Behaviour:
- Reset: clk and rst only. Synchronous, active-high.
  - On reset: state=IDLE, FIFO emptied (pointers 0), rd_valid=0, rd_data=0, busy=0, frame_err=0, overrun=0.
  - Synchronizer flops preset to 1.
  - Reset asserted mid-frame aborts the frame; no partial byte is pushed.
- Input sync: rx passes through 2 flops (rx_s). All decisions use rx_s. rx-to-decision latency is 2 cycles.
- Tick generator:
  - DIV = CLK_HZ/(16*BAUD), integer floor, minimum 1 (13 at defaults).
  - tick is a 1-cycle pulse every DIV clocks.
  - Counter is reset to 0 on entering START so sampling phase aligns to the detected edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, sub-tick count=0.
  - START: at 8th tick, rx_s==0 -> DATA, bit index=0. rx_s==1 -> IDLE (glitch reject; nothing reported).
  - DATA: every 16th tick, sample rx_s into shift register MSB, shifting right. After bit 7 -> STOP.
  - STOP: at 16th tick, rx_s==1 -> push byte, IDLE. rx_s==0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait until rx_s==1, then IDLE. A held-low line therefore produces only one frame_err.
- Sampling points: nominal mid-bit (ticks 8, 24, 40, ...) relative to the synchronized falling edge.
- FIFO:
  - Registered storage; read and write pointers each one bit wider than log2(FIFO_DEPTH), wrapping naturally.
  - rd_data = mem[rd_ptr], first-word-fall-through; it updates the cycle after a pop.
  - rd_valid = (wr_ptr != rd_ptr).
  - rd_en while empty is ignored, with no pointer change.
  - Push while full: byte dropped, overrun pulses, FIFO contents unchanged.
  - Simultaneous pop and push when full: pop is applied first, push is accepted, no overrun, count unchanged.
  - Simultaneous pop and push when empty: pop ignored, push accepted.
- Pulse timing: frame_err and overrun assert in the cycle after the stop-bit sample and last exactly 1 cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; state PARITY is inserted between DATA and STOP and samples at its 16th tick.
  - Extra output port parity_err (1 bit): one-cycle pulse when the XOR of the 8 data bits and the parity bit is 1.
  - A byte with a parity error is discarded, not pushed. The FSM still checks the stop bit.
  - parity_err and frame_err may pulse in different cycles of the same frame.
- Undefined: no PARITY state and no parity_err port; the frame is 8N1.

Test Plan:
- Reset, then idle line high for 1000 cycles -> rd_valid=0, busy=0, no pulses.
- Send 0x55, then 0xA3, at 115200 with CLK_HZ=24000000 -> rd_valid rises after the first stop sample, rd_data=0x55. Pulse rd_en -> rd_data=0xA3. Pulse rd_en again -> rd_valid=0.
- 0.25-bit low glitch on rx -> returns to IDLE, busy deasserts, nothing pushed, no frame_err.
- Frame 0x0F with stop bit forced low, then line held low for 3 bit times -> exactly one frame_err pulse, no push, BREAK held until rx high.
- Five bytes 0x01..0x05 with no reads -> bytes 0x01..0x04 stored, overrun pulses once at byte 5. Second variant: rd_en asserted in the push cycle of byte 5 -> no overrun, FIFO holds 0x02..0x05.
- Assert rst during bit 4 of a frame -> FIFO empty, state IDLE. The next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver with 16x oversampling, 2-flop input
//            synchronizer and a first-word-fall-through receive FIFO.
//            Framing errors and overruns are reported as one-cycle pulses.
//            Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds
//            the parity_err output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int DIV_RAW = CLK_HZ / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4,
    S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;
`endif

  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] div_cnt_q;
  logic          tick;
  logic          start_edge;
  state_t        state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          fe_d, frame_err_q;
  logic          ov_d, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          pe_d, parity_err_q;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, pop, push_ok;

  // Two-flop synchronizer; presets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign start_edge = (state_q == S_IDLE) && !rx_s_q;
  assign tick       = (div_cnt_q == CW'(DIV - 1));

  // Oversample tick divider, re-phased to the detected start edge
  always_ff @(posedge clk) begin
    if (rst || start_edge || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sub_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      frame_err_q  <= fe_d;
      overrun_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= pe_d;
`endif
    end
  end

  // Next-state logic; samples land on sub-tick 8 of start, 16 of later bits
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          sub_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            sub_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            par_bad_d = ^{shift_q, rx_s_q};
            pe_d      = ^{shift_q, rx_s_q};
            state_d   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad_q;
`else
              push = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rd_en && rd_valid;
  assign push_ok = push && (!full || pop);
  assign ov_d    = push && full && !pop;

  // FIFO storage and pointers; a pop frees the slot a same-cycle push uses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid  = (wr_ptr_q != rd_ptr_q);
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire
